// File: rtl/mm_kernel_div_pkg.sv
// Shared types and default widths for the kernel's sequential unsigned divider.
package mm_kernel_div_pkg;

  localparam int unsigned DIV_DIVIDEND_W = 60;
  localparam int unsigned DIV_DIVISOR_W  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mm_kernel_udiv_seq_if.sv
// Operand/result handshake bundle between a divider client (master) and the divider (slave).
interface mm_kernel_udiv_seq_if
  import mm_kernel_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_WIDTH  = DIV_DIVISOR_W
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/mm_udiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module mm_udiv_step
  import mm_kernel_div_pkg::*;
#(
  parameter int unsigned W = DIV_DIVISOR_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_c_o,
  output logic         qbit_c_o
);

  logic [W:0] trial;
  logic       borrow;

  assign trial    = {rem_i, bit_i};
  assign borrow   = trial < {1'b0, div_i};
  assign qbit_c_o = ~borrow;
  // A kept difference is always below the divisor, so it fits back into W bits.
  assign rem_c_o  = borrow ? trial[W-1:0] : W'(trial - {1'b0, div_i});

endmodule

// File: rtl/mm_kernel_udiv_seq.sv
// Sequential unsigned divider: one quotient bit per clock, valid/ready on both sides.
module mm_kernel_udiv_seq
  import mm_kernel_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_WIDTH  = DIV_DIVISOR_W
) (
  input logic                 ap_clk,
  input logic                 ap_rst_n,
  mm_kernel_udiv_seq_if.slave bus
);

  localparam int unsigned CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);
  localparam int unsigned MSB       = DIVIDEND_WIDTH - 1;

  div_state_e                state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] q_q, q_d, quot_q, quot_d;
  logic [DIVISOR_WIDTH-1:0]  d_q, d_d, r_q, r_d, rem_q, rem_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      zflag_q, zflag_d, dbz_q, dbz_d, valid_q, valid_d;
  logic [DIVISOR_WIDTH-1:0]  step_rem;
  logic                      step_qbit;

  mm_udiv_step #(.W(DIVISOR_WIDTH)) u_step (
    .rem_i    (r_q),
    .bit_i    (q_q[MSB]),
    .div_i    (d_q),
    .rem_c_o  (step_rem),
    .qbit_c_o (step_qbit)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zflag_d = zflag_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          q_d     = bus.dividend;
          d_d     = bus.divisor;
          r_d     = '0;
          cnt_d   = '0;
          zflag_d = (bus.divisor == '0);
          state_d = BUSY;
        end
      end
      BUSY: begin
        q_d   = {q_q[MSB-1:0], step_qbit};
        r_d   = step_rem;
        cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
        if (cnt_q == CNT_WIDTH'(DIVIDEND_WIDTH - 1)) begin
          state_d = DONE;
          // With a zero divisor the remainder already equals the low dividend bits.
          quot_d  = zflag_q ? '1 : q_d;
          rem_d   = step_rem;
          dbz_d   = zflag_q;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zflag_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zflag_q <= zflag_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mm_kernel_udiv_seq.sv
// Bench for mm_kernel_udiv_seq: directed corner cases plus a randomized soak against an arithmetic model.
module tb_mm_kernel_udiv_seq;
  import mm_kernel_div_pkg::*;

  localparam int unsigned DW       = DIV_DIVIDEND_W;
  localparam int unsigned VW       = DIV_DIVISOR_W;
  localparam int unsigned LAT      = DW;
  localparam int unsigned SOAK_OPS = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mm_kernel_udiv_seq_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus ();

  mm_kernel_udiv_seq #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the defined zero-divisor result.
  task automatic ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
    if (b == '0) begin
      q = '1;
      r = a[VW-1:0];
      z = 1'b1;
    end else begin
      q = a / DW'(b);
      r = VW'(a % DW'(b));
      z = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    ref_div(a, b, eq, er, ez);
    check_eq({tag, ".quot"}, 128'(bus.quotient), 128'(eq));
    check_eq({tag, ".rem"}, 128'(bus.remainder), 128'(er));
    check_eq({tag, ".dbz"}, 128'(bus.div_by_zero), 128'(ez));
    if (b != '0) begin
      check_eq({tag, ".identity"}, 128'(bus.quotient) * 128'(b) + 128'(bus.remainder), 128'(a));
      check_eq({tag, ".rem_lt_div"}, 128'(bus.remainder < b), 128'(1));
    end
  endtask

  task automatic start_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    check_eq({tag, ".idle_rdy"}, 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid; in_ready must stay low meanwhile.
  task automatic wait_valid(input string tag, output int lat);
    bit rdy_seen = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 4 * LAT) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    check_eq({tag, ".busy_rdy"}, 128'(rdy_seen), 128'(0));
    check_eq({tag, ".latency"}, 128'(lat), 128'(LAT));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check_eq({tag, ".vld_after"}, 128'(bus.out_valid), 128'(0));
    check_eq({tag, ".rdy_after"}, 128'(bus.in_ready), 128'(1));
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int lat;
    start_op(tag, a, b);
    wait_valid(tag, lat);
    check_result(tag, a, b);
    drain(tag);
  endtask

  initial begin
    int               lat;
    int               done_ops;
    int               issued;
    int               cyc;
    bit               acc;
    logic [63:0]      rnd;
    logic [DW-1:0]    a;
    logic [VW-1:0]    b;
    logic [DW-1:0]    ones_dw;
    logic [VW-1:0]    ones_vw;
    logic [DW-1:0]    qa[$];
    logic [VW-1:0]    qb[$];

    ones_dw       = '1;
    ones_vw       = '1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.in_ready", 128'(bus.in_ready), 128'(1));
    check_eq("reset.out_valid", 128'(bus.out_valid), 128'(0));
    check_eq("reset.quotient", 128'(bus.quotient), 128'(0));
    check_eq("reset.remainder", 128'(bus.remainder), 128'(0));
    check_eq("reset.dbz", 128'(bus.div_by_zero), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    run_op("d100_7", DW'(100), VW'(7));
    run_op("dmax_1", ones_dw, VW'(1));
    run_op("dmax_max", ones_dw, ones_vw);
    run_op("d5_9", DW'(5), VW'(9));
    run_op("d1234_0", DW'(1234), VW'(0));

    // Backpressure: hold the result for 10 cycles, poke in_valid mid-stall.
    start_op("bp", DW'(100), VW'(3));
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        bus.in_valid = 1'b1;
        bus.dividend = DW'(7);
        bus.divisor  = VW'(1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_eq("bp.stall_vld", 128'(bus.out_valid), 128'(1));
      check_eq("bp.stall_rdy", 128'(bus.in_ready), 128'(0));
      check_result("bp.stall", DW'(100), VW'(3));
    end
    bus.in_valid = 1'b0;
    drain("bp");
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp.no_stale_vld", 128'(bus.out_valid), 128'(0));
    check_eq("bp.no_stale_rdy", 128'(bus.in_ready), 128'(1));

    // Asynchronous reset in the middle of an operation.
    start_op("rst", DW'(1000), VW'(3));
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst.vld_now", 128'(bus.out_valid), 128'(0));
    check_eq("rst.rdy_now", 128'(bus.in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1 check_eq("rst.vld_held", 128'(bus.out_valid), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", DW'(81), VW'(9));

    // Random soak with random in_valid / out_ready; scoreboard in acceptance order.
    done_ops = 0;
    issued   = 0;
    cyc      = 0;
    while (done_ops < SOAK_OPS && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!bus.in_valid && issued < SOAK_OPS && $urandom_range(0, 2) == 0) begin
        rnd = {$urandom(), $urandom()};
        a   = DW'(rnd) >> $urandom_range(0, DW - 1);
        b   = VW'($urandom()) >> $urandom_range(0, VW - 1);
        if ($urandom_range(0, 31) == 0) b = '0;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (qa.size() == 0) begin
          check_eq("soak.extra_result", 128'(bus.out_valid), 128'(0));
        end else begin
          check_result("soak", qa[0], qb[0]);
          void'(qa.pop_front());
          void'(qb.pop_front());
          done_ops++;
        end
      end
      if (acc) begin
        qa.push_back(bus.dividend);
        qb.push_back(bus.divisor);
        issued++;
      end
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("soak.completed", 128'(done_ops), 128'(SOAK_OPS));
    check_eq("soak.pending", 128'(qa.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
